// File: rtl/alu_flags_wb_if.sv
// Bus interface for the ALU result writeback buffer: the ALU-side accept
// handshake, the register-file-side drain handshake, the flag outputs and the occupancy.
interface alu_flags_wb_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_y;
  logic       in_c;
  logic [3:0] in_op;
  logic [2:0] in_rd;
  logic       in_upd_flags;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_rd;
  logic       c_flag;
  logic       z_flag;
  logic       n_flag;
  logic [2:0] count;

  modport master (
    output in_valid, in_y, in_c, in_op, in_rd, in_upd_flags, out_ready,
    input  in_ready, out_valid, out_data, out_rd, c_flag, z_flag, n_flag, count
  );

  modport slave (
    input  in_valid, in_y, in_c, in_op, in_rd, in_upd_flags, out_ready,
    output in_ready, out_valid, out_data, out_rd, c_flag, z_flag, n_flag, count
  );
endinterface

// File: rtl/alu_flags_wb.sv
// ALU writeback stage: buffers {result, destination} in a small FIFO for the
// register file and maintains the registered C/Z/N flags fed back to the ALU.
module alu_flags_wb #(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_flags_wb_if.slave  bus
);

  localparam int         PTR_W   = $clog2(DEPTH);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] rd;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             n_q, n_d;

  logic accept;
  logic op_invalid;
  logic c_op;
  logic push;
  logic pop;

  // Handshake status comes purely from registered occupancy, so a full buffer
  // never accepts in the same cycle it drains.
  always_comb begin
    bus.in_ready  = (count_q < DEPTH_C);
    bus.out_valid = (count_q != 3'd0);
    bus.out_data  = mem_q[rd_ptr_q].data;
    bus.out_rd    = mem_q[rd_ptr_q].rd;
    bus.c_flag    = c_q;
    bus.z_flag    = z_q;
    bus.n_flag    = n_q;
    bus.count     = count_q;
  end

  // Opcodes 1110/1111 complete the handshake but are otherwise discarded.
  always_comb begin
    accept     = bus.in_valid && bus.in_ready;
    op_invalid = (bus.in_op[3:1] == 3'b111);
    c_op       = bus.in_op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1101};
    push       = accept && !op_invalid;
    pop        = bus.out_valid && bus.out_ready;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{data: bus.in_y, rd: bus.in_rd};
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    if (push && bus.in_upd_flags) begin
      z_d = (bus.in_y == 8'h00);
      n_d = bus.in_y[7];
      if (c_op) begin
        c_d = bus.in_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
    end
  end

endmodule

// File: tb/tb_alu_flags_wb.sv
// Directed bench for alu_flags_wb (DEPTH=2): a table of one-cycle vectors with
// hand-computed results, then hand sequences for back-pressure and pointer wrap.
module tb_alu_flags_wb;

  logic clk;
  logic rst_n;

  alu_flags_wb_if bus ();

  alu_flags_wb #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [7:0] y;
    logic       c;
    logic [3:0] op;
    logic [2:0] rd;
    logic       upd;
    logic       ordy;
    logic [2:0] e_count;
    logic       e_ov;
    logic       e_ir;
    logic       e_c;
    logic       e_z;
    logic       e_n;
    logic [7:0] e_data;
    logic [2:0] e_rd;
  } vec_t;

  vec_t vecs [16];
  int   tests_run;
  int   tests_failed;

  // Drive one cycle of inputs, let the edge happen, and settle just after it.
  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] y,
                               input logic c, input logic [3:0] op, input logic [2:0] rd,
                               input logic upd, input logic ordy);
    rst_n            = r;
    bus.in_valid     = v;
    bus.in_y         = y;
    bus.in_c         = c;
    bus.in_op        = op;
    bus.in_rd        = rd;
    bus.in_upd_flags = upd;
    bus.out_ready    = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [2:0] cnt, input logic ov,
                            input logic ir, input logic c, input logic z, input logic n);
    checkOutput({tag, "_count"}, {5'd0, bus.count}, {5'd0, cnt});
    checkOutput({tag, "_out_valid"}, {7'd0, bus.out_valid}, {7'd0, ov});
    checkOutput({tag, "_in_ready"}, {7'd0, bus.in_ready}, {7'd0, ir});
    checkOutput({tag, "_c"}, {7'd0, bus.c_flag}, {7'd0, c});
    checkOutput({tag, "_z"}, {7'd0, bus.z_flag}, {7'd0, z});
    checkOutput({tag, "_n"}, {7'd0, bus.n_flag}, {7'd0, n});
  endtask

  task automatic checkHead(input string tag, input logic [7:0] data, input logic [2:0] rd);
    checkOutput({tag, "_out_data"}, bus.out_data, data);
    checkOutput({tag, "_out_rd"}, {5'd0, bus.out_rd}, {5'd0, rd});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //           rst v  y      c  op       rd    upd ordy | cnt  ov ir c  z  n  data   rd
    vecs[0]  = '{0, 0, 8'h00, 0, 4'b0000, 3'd0, 0, 0,    3'd0, 0, 1, 0, 0, 0, 8'h00, 3'd0};
    vecs[1]  = '{1, 1, 8'h00, 1, 4'b0000, 3'd1, 1, 0,    3'd1, 1, 1, 1, 1, 0, 8'h00, 3'd1};
    vecs[2]  = '{1, 1, 8'h05, 0, 4'b0001, 3'd2, 1, 0,    3'd2, 1, 0, 0, 0, 0, 8'h00, 3'd1};
    vecs[3]  = '{1, 0, 8'h00, 0, 4'b0000, 3'd0, 0, 1,    3'd1, 1, 1, 0, 0, 0, 8'h05, 3'd2};
    vecs[4]  = '{1, 1, 8'h80, 1, 4'b0100, 3'd3, 1, 0,    3'd2, 1, 0, 0, 0, 1, 8'h05, 3'd2};
    vecs[5]  = '{1, 0, 8'h00, 0, 4'b0000, 3'd0, 0, 1,    3'd1, 1, 1, 0, 0, 1, 8'h80, 3'd3};
    vecs[6]  = '{1, 1, 8'h00, 1, 4'b1111, 3'd4, 1, 0,    3'd1, 1, 1, 0, 0, 1, 8'h80, 3'd3};
    vecs[7]  = '{1, 1, 8'h00, 1, 4'b0000, 3'd5, 0, 0,    3'd2, 1, 0, 0, 0, 1, 8'h80, 3'd3};
    vecs[8]  = '{1, 1, 8'h11, 1, 4'b0000, 3'd6, 1, 1,    3'd1, 1, 1, 0, 0, 1, 8'h00, 3'd5};
    vecs[9]  = '{1, 1, 8'h7F, 1, 4'b1101, 3'd7, 1, 1,    3'd1, 1, 1, 1, 0, 0, 8'h7F, 3'd7};
    vecs[10] = '{1, 1, 8'hFF, 0, 4'b0010, 3'd0, 1, 1,    3'd1, 1, 1, 0, 0, 1, 8'hFF, 3'd0};
    vecs[11] = '{1, 0, 8'h00, 0, 4'b0000, 3'd0, 0, 1,    3'd0, 0, 1, 0, 0, 1, 8'h00, 3'd0};
    vecs[12] = '{1, 0, 8'h00, 0, 4'b0000, 3'd0, 0, 1,    3'd0, 0, 1, 0, 0, 1, 8'h00, 3'd0};
    vecs[13] = '{1, 1, 8'h01, 1, 4'b0011, 3'd2, 1, 1,    3'd1, 1, 1, 1, 0, 0, 8'h01, 3'd2};
    vecs[14] = '{1, 1, 8'h00, 0, 4'b0101, 3'd3, 1, 0,    3'd2, 1, 0, 1, 1, 0, 8'h01, 3'd2};
    vecs[15] = '{0, 1, 8'h22, 1, 4'b0000, 3'd1, 1, 1,    3'd0, 0, 1, 0, 0, 0, 8'h00, 3'd0};

    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_y         = '0;
    bus.in_c         = 1'b0;
    bus.in_op        = '0;
    bus.in_rd        = '0;
    bus.in_upd_flags = 1'b0;
    bus.out_ready    = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].rst_n, vecs[i].valid, vecs[i].y, vecs[i].c, vecs[i].op,
                    vecs[i].rd, vecs[i].upd, vecs[i].ordy);
      checkState(tag, vecs[i].e_count, vecs[i].e_ov, vecs[i].e_ir,
                 vecs[i].e_c, vecs[i].e_z, vecs[i].e_n);
      if (vecs[i].e_ov) begin
        checkHead(tag, vecs[i].e_data, vecs[i].e_rd);
      end
    end

    // Back-pressure: third result is held off until the first entry drains.
    applyStimulus(1, 1, 8'hA1, 0, 4'b0000, 3'd1, 0, 0);
    checkState("bp_a", 3'd1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 8'hA2, 0, 4'b0000, 3'd2, 0, 0);
    checkState("bp_b", 3'd2, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 8'hA3, 0, 4'b0000, 3'd3, 0, 0);
    checkState("bp_c_held", 3'd2, 1, 0, 0, 0, 0);
    checkHead("bp_c_held", 8'hA1, 3'd1);
    applyStimulus(1, 1, 8'hA3, 0, 4'b0000, 3'd3, 0, 1);
    checkState("bp_pop_a", 3'd1, 1, 1, 0, 0, 0);
    checkHead("bp_pop_a", 8'hA2, 3'd2);
    applyStimulus(1, 1, 8'hA3, 0, 4'b0000, 3'd3, 0, 1);
    checkState("bp_pop_b", 3'd1, 1, 1, 0, 0, 0);
    checkHead("bp_pop_b", 8'hA3, 3'd3);
    applyStimulus(1, 0, 8'h00, 0, 4'b0000, 3'd0, 0, 1);
    checkState("bp_drain", 3'd0, 0, 1, 0, 0, 0);

    // Streaming at occupancy one: each edge pops the old head and pushes a new one.
    applyStimulus(1, 1, 8'h40, 0, 4'b0000, 3'd0, 0, 0);
    checkHead("wrap_pre", 8'h40, 3'd0);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] y;
      logic [2:0] rd;
      string      tag;
      y   = 8'h41 + 8'(i);
      rd  = 3'(i);
      tag = $sformatf("wrap%0d", i);
      applyStimulus(1, 1, y, 0, 4'b0000, rd, 0, 1);
      checkOutput({tag, "_count"}, {5'd0, bus.count}, 8'd1);
      checkHead(tag, y, rd);
    end
    applyStimulus(1, 0, 8'h00, 0, 4'b0000, 3'd0, 0, 1);
    checkState("wrap_drain", 3'd0, 0, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
